// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, req/ack memory read, one-cycle ir_load strobe.
// Optional WAIT timeout with sticky fetch_err and terminal ERR state under `define IFETCH_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] ir_data,
    output logic          ir_load,
    output logic [AW-1:0] pc,
    output logic          fetch_err
);

    localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_LOAD = 2'd2
`ifdef IFETCH_TIMEOUT_EN
        , S_ERR = 2'd3
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            mem_req_q, mem_req_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   ir_data_q, ir_data_d;
    logic            ir_load_q, ir_load_d;
    logic            pend_q, pend_d;
    logic [AW-1:0]   pend_tgt_q, pend_tgt_d;

`ifdef IFETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ir_data_d  = ir_data_q;
        ir_load_d  = 1'b0;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
`ifdef IFETCH_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A redirect in IDLE takes priority over launching a fetch.
                if (branch_taken) begin
                    pc_d = branch_target;
                end else if (!stall) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                    state_d    = S_WAIT;
`ifdef IFETCH_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    pend_d    = 1'b0;
                    if (branch_taken || pend_q) begin
                        // Redirected fetch: drop the word, same-cycle target wins.
                        pc_d    = branch_taken ? branch_target : pend_tgt_q;
                        state_d = S_IDLE;
                    end else begin
                        ir_data_d = mem_rdata;
                        ir_load_d = 1'b1;
                        pc_d      = pc_q + 1'b1;
                        state_d   = S_LOAD;
                    end
                end else begin
                    if (branch_taken) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = branch_target;
                    end
`ifdef IFETCH_TIMEOUT_EN
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        mem_req_d = 1'b0;
                        err_d     = 1'b1;
                        state_d   = S_ERR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            S_LOAD: begin
                if (branch_taken) begin
                    pc_d = branch_target;
                end
                state_d = S_IDLE;
            end
`ifdef IFETCH_TIMEOUT_EN
            S_ERR: begin
                state_d = S_ERR;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= S_IDLE;
            pc_q       <= RST_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            ir_data_q  <= '0;
            ir_load_q  <= 1'b0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
`ifdef IFETCH_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ir_data_q  <= ir_data_d;
            ir_load_q  <= ir_load_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
`ifdef IFETCH_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign ir_data  = ir_data_q;
    assign ir_load  = ir_load_q;
    assign pc       = pc_q;
`ifdef IFETCH_TIMEOUT_EN
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule
